// File: rtl/pipelined_controller_pkg.sv
// Shared encodings for the decode-stage controller: opcodes, funcs, ALU ops,
// PC-select codes, the control bundle struct and the mult/div FSM states.
package pipelined_controller_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BGEZ  = 6'h01;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_BGTZ  = 6'h07;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    // MULT..DIVU are consecutive so the func low bits select among them.
    localparam logic [3:0] ALU_NOP   = 4'd0;
    localparam logic [3:0] ALU_ADD   = 4'd1;
    localparam logic [3:0] ALU_SUB   = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_OR    = 4'd4;
    localparam logic [3:0] ALU_NOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;
    localparam logic [3:0] ALU_LUI   = 4'd7;
    localparam logic [3:0] ALU_SHIFT = 4'd8;
    localparam logic [3:0] ALU_MFHI  = 4'd9;
    localparam logic [3:0] ALU_MFLO  = 4'd10;
    localparam logic [3:0] ALU_MULT  = 4'd11;
    localparam logic [3:0] ALU_MULTU = 4'd12;
    localparam logic [3:0] ALU_DIV   = 4'd13;
    localparam logic [3:0] ALU_DIVU  = 4'd14;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_SLL  = 2'b01;
    localparam logic [1:0] SH_SRL  = 2'b10;
    localparam logic [1:0] SH_SRA  = 2'b11;

    localparam logic [1:0] PC_SEQ  = 2'b00;
    localparam logic [1:0] PC_JUMP = 2'b10;
    localparam logic [1:0] PC_JR   = 2'b11;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       regdst;
        logic       regwrite;
        logic       writemem;
        logic       readmem;
        logic       memtoreg;
        logic       signextend;
        logic       branch;
        logic [1:0] shift;
        logic [1:0] pc_source;
        logic       hilo_write;
        logic       illegal;
    } ctrl_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode/func decode into the control bundle, plus the
// mult/div and HI/LO-reader classification used by the interlock.
module control_decode
    import pipelined_controller_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] func,
    output ctrl_t      ctrl,
    output logic       is_muldiv,
    output logic       uses_hilo
);

    logic legal;

    always_comb begin
        ctrl      = CTRL_BUBBLE;
        is_muldiv = 1'b0;
        uses_hilo = 1'b0;
        legal     = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                ctrl.regdst   = 1'b1;
                ctrl.regwrite = 1'b1;
                case (func)
                    FN_ADD, FN_ADDU: ctrl.aluop = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.aluop = ALU_SUB;
                    FN_AND:          ctrl.aluop = ALU_AND;
                    FN_OR:           ctrl.aluop = ALU_OR;
                    FN_NOR:          ctrl.aluop = ALU_NOR;
                    FN_SLT:          ctrl.aluop = ALU_SLT;
                    FN_SLL: begin ctrl.aluop = ALU_SHIFT; ctrl.shift = SH_SLL; end
                    FN_SRL: begin ctrl.aluop = ALU_SHIFT; ctrl.shift = SH_SRL; end
                    FN_SRA: begin ctrl.aluop = ALU_SHIFT; ctrl.shift = SH_SRA; end
                    FN_JR: begin
                        ctrl.regdst    = 1'b0;
                        ctrl.regwrite  = 1'b0;
                        ctrl.pc_source = PC_JR;
                    end
                    FN_MFHI: begin ctrl.aluop = ALU_MFHI; uses_hilo = 1'b1; end
                    FN_MFLO: begin ctrl.aluop = ALU_MFLO; uses_hilo = 1'b1; end
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: begin
                        ctrl.regdst     = 1'b0;
                        ctrl.regwrite   = 1'b0;
                        ctrl.hilo_write = 1'b1;
                        ctrl.aluop      = ALU_MULT + {2'b00, func[1:0]};
                        is_muldiv       = 1'b1;
                    end
                    default: legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                ctrl.aluop = ALU_ADD; ctrl.alusrc = 1'b1; ctrl.regwrite = 1'b1; ctrl.signextend = 1'b1;
            end
            OP_SLTI: begin
                ctrl.aluop = ALU_SLT; ctrl.alusrc = 1'b1; ctrl.regwrite = 1'b1; ctrl.signextend = 1'b1;
            end
            OP_ANDI: begin ctrl.aluop = ALU_AND; ctrl.alusrc = 1'b1; ctrl.regwrite = 1'b1; end
            OP_ORI:  begin ctrl.aluop = ALU_OR;  ctrl.alusrc = 1'b1; ctrl.regwrite = 1'b1; end
            OP_LUI:  begin ctrl.aluop = ALU_LUI; ctrl.alusrc = 1'b1; ctrl.regwrite = 1'b1; end
            OP_LW: begin
                ctrl.aluop      = ALU_ADD;
                ctrl.alusrc     = 1'b1;
                ctrl.regwrite   = 1'b1;
                ctrl.readmem    = 1'b1;
                ctrl.memtoreg   = 1'b1;
                ctrl.signextend = 1'b1;
            end
            OP_SW: begin
                ctrl.aluop = ALU_ADD; ctrl.alusrc = 1'b1; ctrl.writemem = 1'b1; ctrl.signextend = 1'b1;
            end
            OP_BEQ, OP_BNE, OP_BGTZ, OP_BGEZ: begin
                ctrl.aluop = ALU_SUB; ctrl.branch = 1'b1; ctrl.signextend = 1'b1;
            end
            OP_J:    ctrl.pc_source = PC_JUMP;
            OP_JAL:  begin ctrl.pc_source = PC_JUMP; ctrl.regwrite = 1'b1; end
            default: legal = 1'b0;
        endcase
        // Anything undefined becomes a flagged bubble with every write enable off.
        if (!legal) begin
            ctrl         = CTRL_BUBBLE;
            ctrl.illegal = 1'b1;
            is_muldiv    = 1'b0;
            uses_hilo    = 1'b0;
        end
    end

endmodule

// File: rtl/pipelined_controller.sv
// Decode-stage controller: ID/EX control latch with flush/stall, plus the
// mult/div occupancy FSM and HI/LO interlock that drives stall_out.
module pipelined_controller
    import pipelined_controller_pkg::*;
#(
    parameter int ALUOP_W       = 4,
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    input  logic [5:0]         opcode,
    input  logic [5:0]         func,
    input  logic               stall_in,
    input  logic               flush,
    output logic               ex_valid,
    output logic [ALUOP_W-1:0] aluop,
    output logic               alusrc,
    output logic               regdst,
    output logic               regwrite,
    output logic               writemem,
    output logic               readmem,
    output logic               memtoreg,
    output logic               signextend,
    output logic               branch,
    output logic [1:0]         shift,
    output logic [1:0]         pc_source,
    output logic               hilo_write,
    output logic               muldiv_start,
    output logic               muldiv_busy,
    output logic               stall_out,
    output logic               illegal
);

    ctrl_t            dec;
    logic             dec_muldiv;
    logic             dec_hilo;
    ctrl_t            ctrl_q, ctrl_d;
    logic             ex_valid_q, ex_valid_d;
    logic             start_q, start_d;
    md_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             launch;

    control_decode u_decode (
        .opcode    (opcode),
        .func      (func),
        .ctrl      (dec),
        .is_muldiv (dec_muldiv),
        .uses_hilo (dec_hilo)
    );

    assign stall_out = (state_q == ST_BUSY) && instr_valid && (dec_muldiv || dec_hilo);
    assign launch    = !flush && !stall_in && !stall_out && instr_valid && dec_muldiv;

    always_comb begin
        ctrl_d     = ctrl_q;
        ex_valid_d = ex_valid_q;
        start_d    = launch;
        if (flush) begin
            ctrl_d     = CTRL_BUBBLE;
            ex_valid_d = 1'b0;
        end else if (!(stall_in || stall_out)) begin
            ex_valid_d = instr_valid;
            ctrl_d     = instr_valid ? dec : CTRL_BUBBLE;
        end
    end

    // Counter runs MULDIV_CYCLES-1 down to 0, giving MULDIV_CYCLES busy cycles.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_BUSY;
                    cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                end
            end
            ST_BUSY: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q     <= CTRL_BUBBLE;
            ex_valid_q <= 1'b0;
            start_q    <= 1'b0;
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            ex_valid_q <= ex_valid_d;
            start_q    <= start_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign aluop        = ALUOP_W'(ctrl_q.aluop);
    assign alusrc       = ctrl_q.alusrc;
    assign regdst       = ctrl_q.regdst;
    assign regwrite     = ctrl_q.regwrite;
    assign writemem     = ctrl_q.writemem;
    assign readmem      = ctrl_q.readmem;
    assign memtoreg     = ctrl_q.memtoreg;
    assign signextend   = ctrl_q.signextend;
    assign branch       = ctrl_q.branch;
    assign shift        = ctrl_q.shift;
    assign pc_source    = ctrl_q.pc_source;
    assign hilo_write   = ctrl_q.hilo_write;
    assign illegal      = ctrl_q.illegal;
    assign muldiv_start = start_q;
    assign muldiv_busy  = (state_q == ST_BUSY);

endmodule

// File: doc/pipelined_controller.md
Name: pipelined_controller

Overview:
- Decode-stage controller for the pipelined MIPS core.
- Decodes opcode/func into the control bundle and registers it into the ID/EX control latch, with stall-hold and flush-to-bubble.
- Adds multi-cycle MULT/MULTU/DIV/DIVU sequencing with a busy counter and HI/LO interlock.
- Sits between the IF/ID register and the EX stage; the hazard unit drives stall_in and the branch unit drives flush.

Parameters:
ALUOP_W, 4, width of the aluop field
MULDIV_CYCLES, 32, EX cycles a mult/div occupies (≥2)
CNT_W, 6, counter width; must satisfy 2^CNT_W > MULDIV_CYCLES

Ports:
clk  in  1  core clock
rst_n  in  1  reset
instr_valid  in  1  IF/ID holds a real instruction
opcode  in  6  instruction[31:26]
func  in  6  instruction[5:0]
stall_in  in  1  hazard-unit stall; hold the ID/EX latch
flush  in  1  squash the instruction entering ID/EX
ex_valid  out  1  ID/EX latch holds a live instruction
aluop  out  ALUOP_W  registered ALU operation
alusrc, regdst, regwrite, writemem, readmem, memtoreg, signextend, branch  out  1 each  registered controls
shift  out  2  registered shift-select
pc_source  out  2  registered PC-select (00 seq, 10 jump, 11 jr)
hilo_write  out  1  registered; mult/div writes HI/LO
muldiv_start  out  1  one-cycle pulse: mult/div launched
muldiv_busy  out  1  mult/div unit occupied
stall_out  out  1  combinational; freeze IF/ID and PC
illegal  out  1  registered; undefined opcode/func reached EX

Behaviour:
- Reset: asynchronous, active-low on rst_n. Clears every registered output to 0 and aluop to ALU_NOP; busy counter clears to 0.
- Decode table for the existing ISA subset is unchanged:
  - R-type: ADD/ADDU/SUB/SUBU/AND/OR/NOR/SLL/SRL/SRA/SLT/JR.
  - I-type: ADDI, ADDIU, ANDI, BEQ, BNE, BGTZ, BGEZ, LUI, LW, ORI, SLTI, SW.
  - J-type: J, JAL.
- New R-type funcs:
  - MULT 0x18, MULTU 0x19, DIV 0x1A, DIVU 0x1B: hilo_write=1, regwrite=0.
  - MFHI 0x10, MFLO 0x12: regwrite=1, regdst=1.
- Undefined opcode or R-type func decodes to a bubble with illegal=1. All write enables (regwrite, writemem, hilo_write) are 0.
- Latch update on each rising clk, in priority order:
  1. flush: ex_valid=0, all enables 0, aluop=ALU_NOP, illegal=0.
  2. stall_in or stall_out: hold all latch contents.
  3. Otherwise: load the decode. ex_valid=instr_valid. If instr_valid=0, load a bubble.
- Latency: exactly 1 cycle from decode inputs to registered outputs.
- Interlock:
  - stall_out = muldiv_busy AND instr_valid AND the decoded instruction is a mult/div or MFHI/MFLO.
  - Independent instructions proceed while busy.
  - When stall_out=1, the latch holds (behaves as a bubble-hold).
- Mult/div FSM, states IDLE and BUSY:
  - IDLE→BUSY when a mult/div is loaded into the latch (not flushed, not stalled, instr_valid). muldiv_start pulses for that one cycle, aligned with ex_valid. Counter loads MULDIV_CYCLES-1.
  - BUSY: counter decrements each cycle. At 0, move to IDLE next edge.
  - muldiv_busy=1 in BUSY, so busy spans exactly MULDIV_CYCLES cycles after the start edge.
- Boundary conditions:
  - Back-to-back mult/div: the second one stalls until the cycle muldiv_busy drops, then issues; no idle gap is required.
  - flush never aborts an already-launched mult/div. flush on the launch cycle prevents the launch.
  - stall_in and a mult/div arriving together: no launch until stall_in drops.
  - Asynchronous reset mid-BUSY: returns to IDLE and deasserts busy and stall_out immediately.

Decomposition:
- Extend controller_constants.vh with:
  - FN_MULT, FN_MULTU, FN_DIV, FN_DIVU, FN_MFHI, FN_MFLO;
  - ALU_MFHI, ALU_MFLO;
  - PC_SEQ, PC_JUMP, PC_JR.
- The combinational decode is a natural sub-module, control_decode. The top holds the ID/EX latch, FSM and counter.

Test Plan:
- Reset and R-type:
  - Stimulus: rst_n low mid-run, then ADD (op 0, func 0x20, valid).
  - Required: all outputs 0 during reset. One cycle after release+decode: aluop=ALU_ADD, regdst=1, regwrite=1, ex_valid=1.
- MULT then MFLO, MULDIV_CYCLES=4:
  - Stimulus: MULT, then MFLO presented next cycle.
  - Required: muldiv_start pulses once. stall_out=1 for 4 cycles. MFLO reaches EX on the 5th cycle after MULT entered EX.
- Independent instruction during BUSY:
  - Stimulus: MULT, then LW.
  - Required: LW enters EX next cycle, stall_out=0, readmem=1, memtoreg=1.
- Flush and stall:
  - Stimulus: flush with DIV decoded.
  - Required: ex_valid=0, no muldiv_start, busy stays 0.
  - Stimulus: stall_in held 3 cycles with SW latched.
  - Required: writemem=1 held unchanged.
- Illegal opcode:
  - Stimulus: opcode 0x3F.
  - Required: illegal=1, regwrite=writemem=hilo_write=0, ex_valid=1.
- Reset mid-BUSY:
  - Stimulus: DIVU launched, rst_n pulsed low at cycle 2.
  - Required: muldiv_busy=0 asynchronously. A following MFHI issues without stall.
